// File: rtl/inst_sequencer_if.sv
// Bundles the memory handshake and control-decoder signals of the
// instruction sequencer. The sequencer connects through the slave modport;
// the memory/decoder side (or a testbench) uses the master modport.
interface inst_sequencer_if;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic        J;
  logic        LJ;
  logic [15:0] jump_target;
  logic        WC;
  logic        carry_in;
  logic [7:0]  inst;
  logic        cycle;
  logic        carry;
  logic [15:0] pc;
  logic        fetch;
  logic        exec;
  logic        retire;

  modport slave (
    input  mem_data, mem_valid, J, LJ, jump_target, WC, carry_in,
    output inst, cycle, carry, pc, fetch, exec, retire
  );

  modport master (
    output mem_data, mem_valid, J, LJ, jump_target, WC, carry_in,
    input  inst, cycle, carry, pc, fetch, exec, retire
  );
endinterface

// File: rtl/inst_sequencer.sv
// Three-state instruction sequencer: FETCH latches an instruction byte,
// EXEC0 runs single-cycle instructions (or waits on the data access of a
// memory instruction), EXEC1 finishes memory instructions. The program
// counter, instruction register and carry flag live here.
module inst_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic            clk,
  input logic            rst,
  inst_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC0 = 2'd1,
    S_EXEC1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic [7:0]  r_inst;
  logic [7:0]  w_inst_nxt;
  logic        r_carry;
  logic        w_carry_nxt;
  logic        r_retire;
  logic        w_commit;

  // Next-state logic: everything holds unless the current state acts on it.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_carry_nxt = r_carry;
    w_commit    = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (bus.mem_valid) begin
          w_inst_nxt  = bus.mem_data;
          w_pc_nxt    = r_pc + 16'd1;
          w_state_nxt = S_EXEC0;
        end
      end
      S_EXEC0: begin
        if (!r_inst[7]) begin
          // Single-cycle instruction commits here; only LJ may redirect.
          w_commit    = 1'b1;
          w_state_nxt = S_FETCH;
          if (bus.LJ) begin
            w_pc_nxt = bus.jump_target;
          end
        end else if (bus.mem_valid) begin
          // Memory instruction: data access done, finish in EXEC1.
          w_state_nxt = S_EXEC1;
        end
      end
      S_EXEC1: begin
        w_commit    = 1'b1;
        w_state_nxt = S_FETCH;
        if (bus.J) begin
          w_pc_nxt = bus.jump_target;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    // Carry is only ever written on a commit edge.
    if (w_commit && bus.WC) begin
      w_carry_nxt = bus.carry_in;
    end
  end

  // State register; reset discards any in-flight instruction without commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_inst   <= 8'h00;
      r_carry  <= 1'b0;
      r_retire <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_inst   <= w_inst_nxt;
      r_carry  <= w_carry_nxt;
      r_retire <= w_commit;
    end
  end

  // Outputs are pure decodes of registered state.
  assign bus.inst   = r_inst;
  assign bus.pc     = r_pc;
  assign bus.carry  = r_carry;
  assign bus.retire = r_retire;
  assign bus.fetch  = (r_state == S_FETCH);
  assign bus.exec   = (r_state == S_EXEC0) || (r_state == S_EXEC1);
  assign bus.cycle  = (r_state == S_EXEC1);

endmodule

// File: tb/tb_inst_sequencer.sv
// Testbench for inst_sequencer: directed scenarios plus a randomised
// back-to-back run, with commit results tracked through a scoreboard queue.
module tb_inst_sequencer;

  typedef struct {
    logic [15:0] pc;
    logic        carry;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];
  exp_t e;

  inst_sequencer_if bus();

  inst_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_data    = 8'h00;
    bus.mem_valid   = 1'b0;
    bus.J           = 1'b0;
    bus.LJ          = 1'b0;
    bus.jump_target = 16'h0000;
    bus.WC          = 1'b0;
    bus.carry_in    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (bus.fetch !== 1'b1) begin n_errors++; $display("FAIL reset_fetch: got %b want 1", bus.fetch); end
    n_checks++; if (bus.exec !== 1'b0) begin n_errors++; $display("FAIL reset_exec: got %b want 0", bus.exec); end
    n_checks++; if (bus.cycle !== 1'b0) begin n_errors++; $display("FAIL reset_cycle: got %b want 0", bus.cycle); end
    n_checks++; if (bus.retire !== 1'b0) begin n_errors++; $display("FAIL reset_retire: got %b want 0", bus.retire); end
    n_checks++; if (bus.pc !== 16'h0000) begin n_errors++; $display("FAIL reset_pc: got %h want 0000", bus.pc); end
    n_checks++; if (bus.inst !== 8'h00) begin n_errors++; $display("FAIL reset_inst: got %h want 00", bus.inst); end
    n_checks++; if (bus.carry !== 1'b0) begin n_errors++; $display("FAIL reset_carry: got %b want 0", bus.carry); end
  endtask

  task automatic test_single_cycle();
    bus.mem_data  = 8'h42;
    bus.mem_valid = 1'b1;
    sb_q.push_back('{pc: 16'h0001, carry: 1'b0});
    tick();
    bus.mem_valid = 1'b0;
    n_checks++; if (bus.inst !== 8'h42) begin n_errors++; $display("FAIL single_inst: got %h want 42", bus.inst); end
    n_checks++; if (bus.pc !== 16'h0001) begin n_errors++; $display("FAIL single_pc: got %h want 0001", bus.pc); end
    n_checks++; if (bus.exec !== 1'b1 || bus.fetch !== 1'b0 || bus.cycle !== 1'b0 || bus.retire !== 1'b0) begin
      n_errors++; $display("FAIL single_exec0: exec=%b fetch=%b cycle=%b retire=%b want 1 0 0 0", bus.exec, bus.fetch, bus.cycle, bus.retire); end
    tick();
    n_checks++; if (bus.retire !== 1'b1 || bus.fetch !== 1'b1 || bus.cycle !== 1'b0) begin
      n_errors++; $display("FAIL single_commit: retire=%b fetch=%b cycle=%b want 1 1 0", bus.retire, bus.fetch, bus.cycle); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++; if (bus.pc !== e.pc || bus.carry !== e.carry) begin
        n_errors++; $display("FAIL single_sb: pc=%h carry=%b want pc=%h carry=%b", bus.pc, bus.carry, e.pc, e.carry); end
    end
    tick();
    n_checks++; if (bus.retire !== 1'b0 || bus.pc !== 16'h0001) begin
      n_errors++; $display("FAIL single_pulse: retire=%b pc=%h want 0 0001", bus.retire, bus.pc); end
  endtask

  task automatic test_mem_jump();
    bus.mem_data  = 8'hF0;
    bus.mem_valid = 1'b1;
    tick();
    n_checks++; if (bus.pc !== 16'h0002 || bus.inst !== 8'hF0 || bus.cycle !== 1'b0) begin
      n_errors++; $display("FAIL memj_fetch: pc=%h inst=%h cycle=%b want 0002 f0 0", bus.pc, bus.inst, bus.cycle); end
    tick();
    n_checks++; if (bus.cycle !== 1'b1 || bus.retire !== 1'b0 || bus.pc !== 16'h0002) begin
      n_errors++; $display("FAIL memj_exec1: cycle=%b retire=%b pc=%h want 1 0 0002", bus.cycle, bus.retire, bus.pc); end
    bus.mem_valid   = 1'b0;
    bus.J           = 1'b1;
    bus.jump_target = 16'h1234;
    sb_q.push_back('{pc: 16'h1234, carry: 1'b0});
    tick();
    bus.J = 1'b0;
    n_checks++; if (bus.retire !== 1'b1 || bus.cycle !== 1'b0 || bus.fetch !== 1'b1) begin
      n_errors++; $display("FAIL memj_commit: retire=%b cycle=%b fetch=%b want 1 0 1", bus.retire, bus.cycle, bus.fetch); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++; if (bus.pc !== e.pc || bus.carry !== e.carry) begin
        n_errors++; $display("FAIL memj_sb: pc=%h carry=%b want pc=%h carry=%b", bus.pc, bus.carry, e.pc, e.carry); end
    end
    tick();
    n_checks++; if (bus.retire !== 1'b0) begin n_errors++; $display("FAIL memj_pulse: retire=%b want 0", bus.retire); end
  endtask

  task automatic test_wrap_lj();
    // Jump to FFFF via LJ on a single-cycle instruction at 1234.
    bus.mem_data  = 8'h00;
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid   = 1'b0;
    bus.LJ          = 1'b1;
    bus.jump_target = 16'hFFFF;
    sb_q.push_back('{pc: 16'hFFFF, carry: 1'b0});
    tick();
    bus.LJ = 1'b0;
    n_checks++; if (bus.retire !== 1'b1) begin n_errors++; $display("FAIL wrap_lj1_retire: got %b want 1", bus.retire); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++; if (bus.pc !== e.pc || bus.carry !== e.carry) begin
        n_errors++; $display("FAIL wrap_lj1_sb: pc=%h carry=%b want pc=%h carry=%b", bus.pc, bus.carry, e.pc, e.carry); end
    end
    bus.mem_data  = 8'h14;
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    n_checks++; if (bus.pc !== 16'h0000 || bus.inst !== 8'h14) begin
      n_errors++; $display("FAIL wrap_pc: pc=%h inst=%h want 0000 14", bus.pc, bus.inst); end
    bus.LJ          = 1'b1;
    bus.jump_target = 16'hABCD;
    sb_q.push_back('{pc: 16'hABCD, carry: 1'b0});
    tick();
    bus.LJ = 1'b0;
    n_checks++; if (bus.retire !== 1'b1) begin n_errors++; $display("FAIL wrap_lj2_retire: got %b want 1", bus.retire); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++; if (bus.pc !== e.pc || bus.carry !== e.carry) begin
        n_errors++; $display("FAIL wrap_lj2_sb: pc=%h carry=%b want pc=%h carry=%b", bus.pc, bus.carry, e.pc, e.carry); end
    end
  endtask

  task automatic test_stall_carry();
    bus.mem_data  = 8'h80;
    bus.mem_valid = 1'b1;
    tick();
    // Stall in EXEC0 with carry write and LJ asserted; neither may act.
    bus.mem_data    = 8'h33;
    bus.mem_valid   = 1'b0;
    bus.WC          = 1'b1;
    bus.carry_in    = 1'b1;
    bus.LJ          = 1'b1;
    bus.jump_target = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.exec !== 1'b1 || bus.cycle !== 1'b0 || bus.inst !== 8'h80 || bus.pc !== 16'hABCE ||
                      bus.carry !== 1'b0 || bus.retire !== 1'b0) begin
        n_errors++; $display("FAIL stall_%0d: exec=%b cycle=%b inst=%h pc=%h carry=%b retire=%b want 1 0 80 abce 0 0",
                             i, bus.exec, bus.cycle, bus.inst, bus.pc, bus.carry, bus.retire); end
    end
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    n_checks++; if (bus.cycle !== 1'b1 || bus.carry !== 1'b0 || bus.pc !== 16'hABCE || bus.retire !== 1'b0) begin
      n_errors++; $display("FAIL stall_to_exec1: cycle=%b carry=%b pc=%h retire=%b want 1 0 abce 0", bus.cycle, bus.carry, bus.pc, bus.retire); end
    // EXEC1: LJ still high must be ignored, WC commits carry.
    sb_q.push_back('{pc: 16'hABCE, carry: 1'b1});
    tick();
    bus.LJ = 1'b0;
    bus.WC = 1'b0;
    n_checks++; if (bus.retire !== 1'b1) begin n_errors++; $display("FAIL carry_retire: got %b want 1", bus.retire); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++; if (bus.pc !== e.pc || bus.carry !== e.carry) begin
        n_errors++; $display("FAIL carry_sb: pc=%h carry=%b want pc=%h carry=%b", bus.pc, bus.carry, e.pc, e.carry); end
    end
  endtask

  task automatic test_reset_exec1();
    bus.mem_data  = 8'h80;
    bus.mem_valid = 1'b1;
    tick();
    tick();
    bus.mem_valid = 1'b0;
    n_checks++; if (bus.cycle !== 1'b1 || bus.carry !== 1'b1) begin
      n_errors++; $display("FAIL rstx_setup: cycle=%b carry=%b want 1 1", bus.cycle, bus.carry); end
    bus.J           = 1'b1;
    bus.jump_target = 16'h7777;
    bus.WC          = 1'b1;
    bus.carry_in    = 1'b1;
    rst             = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    n_checks++; if (bus.pc !== 16'h0000 || bus.carry !== 1'b0 || bus.retire !== 1'b0 || bus.fetch !== 1'b1 || bus.inst !== 8'h00) begin
      n_errors++; $display("FAIL rstx_state: pc=%h carry=%b retire=%b fetch=%b inst=%h want 0000 0 0 1 00",
                           bus.pc, bus.carry, bus.retire, bus.fetch, bus.inst); end
    tick();
    n_checks++; if (bus.retire !== 1'b0 || bus.pc !== 16'h0000) begin
      n_errors++; $display("FAIL rstx_after: retire=%b pc=%h want 0 0000", bus.retire, bus.pc); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] m_pc;
    logic        m_carry;
    logic [7:0]  op;
    logic [15:0] tgt;
    logic        jmp, wc, cin;
    int          stalls;
    m_pc    = 16'h0000;
    m_carry = 1'b0;
    for (int i = 0; i < 24; i++) begin
      op     = 8'($urandom);
      tgt    = 16'($urandom);
      jmp    = 1'($urandom);
      wc     = 1'($urandom);
      cin    = 1'($urandom);
      stalls = $urandom_range(0, 2);
      // FETCH stalls with stray decoder inputs active.
      bus.mem_valid = 1'b0;
      bus.J = 1'b1; bus.LJ = 1'b1; bus.WC = 1'b1; bus.carry_in = ~m_carry;
      bus.jump_target = tgt;
      for (int s = 0; s < stalls; s++) tick();
      bus.mem_data  = op;
      bus.mem_valid = 1'b1;
      tick();
      m_pc = m_pc + 16'd1;
      n_checks++; if (bus.pc !== m_pc || bus.inst !== op || bus.carry !== m_carry || bus.retire !== 1'b0) begin
        n_errors++; $display("FAIL b2b_fetch_%0d: pc=%h inst=%h carry=%b retire=%b want %h %h %b 0",
                             i, bus.pc, bus.inst, bus.carry, bus.retire, m_pc, op, m_carry); end
      if (op[7]) begin
        bus.mem_valid = 1'b0;
        for (int s = 0; s < stalls; s++) tick();
        bus.mem_valid = 1'b1;
        tick();
        n_checks++; if (bus.cycle !== 1'b1 || bus.pc !== m_pc || bus.carry !== m_carry || bus.retire !== 1'b0) begin
          n_errors++; $display("FAIL b2b_exec0_%0d: cycle=%b pc=%h carry=%b retire=%b want 1 %h %b 0",
                               i, bus.cycle, bus.pc, bus.carry, bus.retire, m_pc, m_carry); end
        bus.mem_valid = 1'b0;
        bus.J = jmp; bus.LJ = ~jmp;
      end else begin
        bus.mem_valid = 1'b0;
        bus.LJ = jmp; bus.J = 1'b1;
      end
      bus.WC = wc; bus.carry_in = cin;
      if (jmp) m_pc = tgt;
      if (wc) m_carry = cin;
      sb_q.push_back('{pc: m_pc, carry: m_carry});
      tick();
      n_checks++; if (bus.retire !== 1'b1 || bus.fetch !== 1'b1) begin
        n_errors++; $display("FAIL b2b_retire_%0d: retire=%b fetch=%b want 1 1", i, bus.retire, bus.fetch); end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++; if (bus.pc !== e.pc || bus.carry !== e.carry) begin
          n_errors++; $display("FAIL b2b_sb_%0d: pc=%h carry=%b want pc=%h carry=%b", i, bus.pc, bus.carry, e.pc, e.carry); end
      end
    end
    idle_inputs();
    tick();
    n_checks++; if (bus.retire !== 1'b0) begin n_errors++; $display("FAIL b2b_tail: retire=%b want 0", bus.retire); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_single_cycle();
    test_mem_jump();
    test_wrap_lj();
    test_stall_carry();
    test_reset_exec1();
    test_back_to_back();
    n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL sb_empty: %0d left want 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, program counter value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_data  input  8  byte returned by memory for the current request.
REQ-005 mem_valid  input  1  mem_data valid / data access complete this cycle.
REQ-006 J  input  1  jump request from control decoder (sampled in EXEC1 only).
REQ-007 LJ  input  1  link-jump request from control decoder (sampled in EXEC0 only).
REQ-008 jump_target  input  16  destination address for J / LJ.
REQ-009 WC  input  1  carry write enable from control decoder.
REQ-010 carry_in  input  1  ALU carry-out.
REQ-011 inst  output  8  instruction register, drives the control decoder.
REQ-012 cycle  output  1  0 in first execute cycle, 1 in second execute cycle of memory instructions.
REQ-013 carry  output  1  carry flag, drives the control decoder.
REQ-014 pc  output  16  program counter / fetch address.
REQ-015 fetch  output  1  instruction fetch request, high only in FETCH.
REQ-016 exec  output  1  high in EXEC0 and EXEC1 (control outputs meaningful).
REQ-017 retire  output  1  one-cycle pulse on the edge an instruction commits.

Function
REQ-018 States: FETCH, EXEC0, EXEC1; encoding free; cycle = (state==EXEC1).
REQ-019 FETCH: fetch=1; mem_valid=0 -> hold all state; mem_valid=1 -> inst<=mem_data, pc<=pc+1, next EXEC0.
REQ-020 pc increment wraps 16'hFFFF -> 16'h0000, no flag.
REQ-021 EXEC0, inst[7]=0 (single-cycle): commit same edge; next FETCH.
REQ-022 EXEC0, inst[7]=0, LJ=1: pc<=jump_target at commit.
REQ-023 EXEC0, inst[7]=1 (memory instruction): mem_valid=0 -> stay EXEC0 (stall, no state change); mem_valid=1 -> next EXEC1, no commit.
REQ-024 EXEC0 with inst[7]=1 ignores LJ.
REQ-025 EXEC1: always commits after one cycle; next FETCH; J=1 -> pc<=jump_target.
REQ-026 EXEC1 ignores LJ; J is ignored outside EXEC1.
REQ-027 Commit: retire=1 for exactly that cycle; WC=1 -> carry<=carry_in; WC=0 -> carry holds.
REQ-028 carry never changes outside a commit edge, including stalls and EXEC0 of memory instructions.
REQ-029 inst holds from latch until next FETCH completes; unchanged during stalls.
REQ-030 Jump load takes priority over any increment; no pc change in EXEC states otherwise.
REQ-031 Throughput: single-cycle instruction 2 clocks, memory instruction 3 clocks, plus mem_valid stall cycles.
REQ-032 retire, fetch, exec are registered-state decodes: no combinational path from mem_valid/J/LJ to them.

Reset
REQ-033 rst=1 at an edge: state<=FETCH, pc<=RESET_PC, inst<=8'h00, carry<=0; retire=0 in the following cycle.
REQ-034 Reset overrides every other input, including mid-stall and EXEC1 with J=1; in-flight instruction is discarded without commit.
REQ-035 Outputs after reset: fetch=1, exec=0, cycle=0, retire=0.

Verification
REQ-036 Reset, mem_valid=1, mem_data=8'h42 -> edge 1: inst=42, pc=0001, EXEC0; edge 2: retire=1, FETCH, cycle=0 throughout.
REQ-037 Fetch 8'hF0 (inst[7:5]=111) then EXEC0 mem_valid=1, EXEC1 J=1, jump_target=1234 -> cycle=1 for one cycle, pc=1234 after, retire one pulse.
REQ-038 pc=FFFF, fetch valid -> pc=0000; EXEC0 with LJ=1, target=ABCD on 8'h14 -> pc=ABCD.
REQ-039 Memory instruction 8'h80, mem_valid held 0 for 3 cycles in EXEC0 -> stays EXEC0, inst/pc/carry unchanged, no retire; then valid -> EXEC1.
REQ-040 WC=1, carry_in=1 on EXEC0 of memory instruction -> carry stays 0; WC=1, carry_in=1 in EXEC1 -> carry=1 after commit.
REQ-041 rst asserted in EXEC1 with J=1, WC=1, carry_in=1 -> pc=RESET_PC, carry=0, no retire, FETCH.
